branch_redirect_ctrl: RTL and testbench

//  Sequences branch resolution in the ID stage and PC redirection for the 5-stage MIPS pipeline.
//  - Stalls an ID-stage branch until its rs/rt operands can be compared in ID.
//  - Arbitrates EX-stage PC changes (jr/jal) against ID-stage taken branches.
//  - Flushes the wrong-path instructions.
//  - Holds the redirect target until the fetch unit accepts it.
//  - Keeps saturating performance counters.

---
 rtl/branch_redirect_ctrl_pkg.sv | 23 ++
 rtl/branch_redirect_ctrl_dep.sv | 39 +++
 rtl/branch_redirect_ctrl.sv | 156 +++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared constants and enumerations for the ID-stage branch / PC redirect controller.
package branch_redirect_ctrl_pkg;

  localparam int BRC_PC_WIDTH  = 32;
  localparam int BRC_AWIDTH    = 5;
  localparam int BRC_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    BRC_IDLE  = 2'd0,
    BRC_STALL = 2'd1,
    BRC_REDIR = 2'd2
  } brc_state_e;

  typedef enum logic [1:0] {
    NEED_NONE = 2'd0,
    NEED_ONE  = 2'd1,
    NEED_TWO  = 2'd2
  } brc_need_e;

  // Extra STALL cycles after the first hazard cycle of a load-use on a branch operand.
  localparam logic [1:0] LOAD_USE_EXTRA = 2'd1;

endpackage

// File: rtl/branch_redirect_ctrl_dep.sv
// Operand readiness for an ID-stage compare: how many cycles the branch must wait
// for a producer still in EX or MEM to deliver rs/rt.
module branch_dep_check
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int AWIDTH = BRC_AWIDTH
) (
  input  logic [AWIDTH-1:0] i_id_rs,
  input  logic [AWIDTH-1:0] i_id_rt,
  input  logic              i_ex_regwrite,
  input  logic              i_ex_memread,
  input  logic [AWIDTH-1:0] i_ex_rd,
  input  logic              i_mem_memread,
  input  logic [AWIDTH-1:0] i_mem_rd,
  output logic [1:0]        o_need
);

  logic ex_hit_s;
  logic mem_hit_s;

  // $0 is hard-wired zero, so a write to it never creates a dependency.
  assign ex_hit_s  = (i_ex_rd != {AWIDTH{1'b0}}) &&
                     ((i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt));
  assign mem_hit_s = (i_mem_rd != {AWIDTH{1'b0}}) &&
                     ((i_mem_rd == i_id_rs) || (i_mem_rd == i_id_rt));

  // Highest need wins: a load in EX outranks any single-cycle producer.
  always_comb begin
    o_need = NEED_NONE;
    if (i_ex_memread && ex_hit_s) begin
      o_need = NEED_TWO;
    end else if ((i_ex_regwrite && ex_hit_s) || (i_mem_memread && mem_hit_s)) begin
      o_need = NEED_ONE;
    end else begin
      o_need = NEED_NONE;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution sequencing and PC redirect hand-off to fetch, with saturating
// redirect / stall performance counters.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int PC_WIDTH  = BRC_PC_WIDTH,
  parameter int AWIDTH    = BRC_AWIDTH,
  parameter int CNT_WIDTH = BRC_CNT_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_id_branch,
  input  logic                 i_id_taken,
  input  logic [PC_WIDTH-1:0]  i_id_target,
  input  logic [AWIDTH-1:0]    i_id_rs,
  input  logic [AWIDTH-1:0]    i_id_rt,
  input  logic                 i_ex_regwrite,
  input  logic                 i_ex_memread,
  input  logic [AWIDTH-1:0]    i_ex_rd,
  input  logic                 i_mem_memread,
  input  logic [AWIDTH-1:0]    i_mem_rd,
  input  logic                 i_ex_change_pc,
  input  logic [PC_WIDTH-1:0]  i_ex_target,
  input  logic                 i_if_ready,
  output logic                 o_stall,
  output logic                 o_bubble_idex,
  output logic                 o_flush_ifid,
  output logic                 o_redirect_valid,
  output logic [PC_WIDTH-1:0]  o_redirect_pc,
  output logic [CNT_WIDTH-1:0] o_taken_cnt,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  brc_state_e           state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [PC_WIDTH-1:0]  target_q, target_d;
  logic                 valid_q;
  logic [CNT_WIDTH-1:0] taken_cnt_q, stall_cnt_q;

  logic [1:0] need_s;
  logic       stall_s;
  logic       bubble_s;
  logic       flush_s;
  logic       issue_s;

  branch_dep_check #(.AWIDTH(AWIDTH)) u_dep (
    .i_id_rs       (i_id_rs),
    .i_id_rt       (i_id_rt),
    .i_ex_regwrite (i_ex_regwrite),
    .i_ex_memread  (i_ex_memread),
    .i_ex_rd       (i_ex_rd),
    .i_mem_memread (i_mem_memread),
    .i_mem_rd      (i_mem_rd),
    .o_need        (need_s)
  );

  // Next-state, target capture and pipeline-control decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    flush_s  = 1'b0;
    issue_s  = 1'b0;
    if (i_ex_change_pc) begin
      // jr/jal already left ID: only the younger wrong-path work is squashed.
      target_d = i_ex_target;
      flush_s  = 1'b1;
      bubble_s = 1'b1;
      issue_s  = 1'b1;
      cnt_d    = 2'd0;
      state_d  = BRC_REDIR;
    end else begin
      case (state_q)
        BRC_IDLE: begin
          if (i_id_branch && (need_s != NEED_NONE)) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
            if (need_s == NEED_TWO) begin
              cnt_d   = LOAD_USE_EXTRA;
              state_d = BRC_STALL;
            end else begin
              state_d = BRC_IDLE;
            end
          end else if (i_id_branch && i_id_taken) begin
            target_d = i_id_target;
            flush_s  = 1'b1;
            issue_s  = 1'b1;
            state_d  = BRC_REDIR;
          end else begin
            state_d = BRC_IDLE;
          end
        end
        BRC_STALL: begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
          cnt_d    = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            cnt_d   = 2'd0;
            state_d = BRC_IDLE;
          end else begin
            state_d = BRC_STALL;
          end
        end
        BRC_REDIR: begin
          if (i_if_ready) begin
            state_d = BRC_IDLE;
          end else begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
          end
        end
        default: begin
          cnt_d   = 2'd0;
          state_d = BRC_IDLE;
        end
      endcase
    end
  end

  // State, held target and performance counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= BRC_IDLE;
      cnt_q       <= 2'd0;
      target_q    <= {PC_WIDTH{1'b0}};
      valid_q     <= 1'b0;
      taken_cnt_q <= {CNT_WIDTH{1'b0}};
      stall_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      valid_q  <= (state_d == BRC_REDIR);
      if (issue_s && !(&taken_cnt_q)) begin
        taken_cnt_q <= taken_cnt_q + CNT_ONE;
      end
      if (stall_s && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
    end
  end

  // Pipeline controls are quiet while reset is held so a frozen pipe sees no spurious kill.
  assign o_stall          = i_rst & stall_s;
  assign o_bubble_idex    = i_rst & bubble_s;
  assign o_flush_ifid     = i_rst & flush_s;
  assign o_redirect_valid = valid_q;
  assign o_redirect_pc    = target_q;
  assign o_taken_cnt      = taken_cnt_q;
  assign o_stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: a cycle-level behavioural model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_branch_redirect_ctrl;

  localparam int PW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_id_branch, i_id_taken;
  logic [PW-1:0] i_id_target;
  logic [AW-1:0] i_id_rs, i_id_rt;
  logic          i_ex_regwrite, i_ex_memread;
  logic [AW-1:0] i_ex_rd;
  logic          i_mem_memread;
  logic [AW-1:0] i_mem_rd;
  logic          i_ex_change_pc;
  logic [PW-1:0] i_ex_target;
  logic          i_if_ready;
  logic          o_stall, o_bubble_idex, o_flush_ifid, o_redirect_valid;
  logic [PW-1:0] o_redirect_pc;
  logic [CW-1:0] o_taken_cnt, o_stall_cnt;

  int n_checks = 0;
  int n_err    = 0;

  branch_redirect_ctrl #(.PC_WIDTH(PW), .AWIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_id_branch(i_id_branch), .i_id_taken(i_id_taken), .i_id_target(i_id_target),
    .i_id_rs(i_id_rs), .i_id_rt(i_id_rt),
    .i_ex_regwrite(i_ex_regwrite), .i_ex_memread(i_ex_memread), .i_ex_rd(i_ex_rd),
    .i_mem_memread(i_mem_memread), .i_mem_rd(i_mem_rd),
    .i_ex_change_pc(i_ex_change_pc), .i_ex_target(i_ex_target), .i_if_ready(i_if_ready),
    .o_stall(o_stall), .o_bubble_idex(o_bubble_idex), .o_flush_ifid(o_flush_ifid),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .o_taken_cnt(o_taken_cnt), .o_stall_cnt(o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a pending redirect, how many more hazard cycles are owed, and event tallies.
  bit          m_ok = 1'b0;
  bit          m_pend;
  int          m_left;
  logic [31:0] m_tgt;
  int          m_taken, m_stalls;

  function automatic int need_of();
    bit ex_hit, mem_hit;
    ex_hit  = (i_ex_rd != 0) && ((i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt));
    mem_hit = (i_mem_rd != 0) && ((i_mem_rd == i_id_rs) || (i_mem_rd == i_id_rt));
    if (i_ex_memread && ex_hit) return 2;
    if ((i_ex_regwrite && ex_hit) || (i_mem_memread && mem_hit)) return 1;
    return 0;
  endfunction

  // {stall, bubble, flush} the pipeline must see this cycle
  function automatic logic [2:0] exp_ctl();
    logic [2:0] r;
    r = 3'b000;
    if (!i_rst) r = 3'b000;
    else if (i_ex_change_pc) r = 3'b011;
    else if (m_pend) r = i_if_ready ? 3'b000 : 3'b110;
    else if (m_left > 0) r = 3'b110;
    else if (i_id_branch) begin
      if (need_of() > 0) r = 3'b110;
      else if (i_id_taken) r = 3'b001;
    end
    return r;
  endfunction

  always @(posedge i_clk) begin
    logic [2:0] c;
    c = exp_ctl();
    m_ok <= 1'b1;
    if (!i_rst) begin
      m_pend <= 1'b0; m_left <= 0; m_tgt <= 32'h0; m_taken <= 0; m_stalls <= 0;
    end else begin
      if (c[2]) m_stalls <= (m_stalls >= CMAX) ? CMAX : m_stalls + 1;
      if (i_ex_change_pc) begin
        m_pend <= 1'b1; m_tgt <= i_ex_target; m_left <= 0;
        m_taken <= (m_taken >= CMAX) ? CMAX : m_taken + 1;
      end else if (m_pend) begin
        if (i_if_ready) m_pend <= 1'b0;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end else if (i_id_branch) begin
        if (need_of() == 2) m_left <= 1;
        else if (need_of() == 0 && i_id_taken) begin
          m_pend <= 1'b1; m_tgt <= i_id_target;
          m_taken <= (m_taken >= CMAX) ? CMAX : m_taken + 1;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    logic [2:0] c;
    if (m_ok) begin
      c = exp_ctl();
      chk("stall",     32'(o_stall),          32'(c[2]));
      chk("bubble",    32'(o_bubble_idex),    32'(c[1]));
      chk("flush",     32'(o_flush_ifid),     32'(c[0]));
      chk("rvalid",    32'(o_redirect_valid), 32'(m_pend));
      chk("rpc",       o_redirect_pc,         m_tgt);
      chk("taken_cnt", 32'(o_taken_cnt),      m_taken);
      chk("stall_cnt", 32'(o_stall_cnt),      m_stalls);
    end
  end

  task automatic nxt();
    @(posedge i_clk); #1;
  endtask

  task automatic neg();
    @(negedge i_clk);
  endtask

  task automatic idle_in();
    i_id_branch = 1'b0; i_id_taken = 1'b0; i_id_target = 32'h0;
    i_id_rs = 5'd0; i_id_rt = 5'd0;
    i_ex_regwrite = 1'b0; i_ex_memread = 1'b0; i_ex_rd = 5'd0;
    i_mem_memread = 1'b0; i_mem_rd = 5'd0;
    i_ex_change_pc = 1'b0; i_ex_target = 32'h0; i_if_ready = 1'b1;
  endtask

  task automatic br(input logic tk, input logic [31:0] tgt, input logic [4:0] rs, input logic [4:0] rt);
    i_id_branch = 1'b1; i_id_taken = tk; i_id_target = tgt; i_id_rs = rs; i_id_rt = rt;
  endtask

  initial begin
    i_rst = 1'b0;
    idle_in();
    // 1: reset held two cycles
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_valid", 32'(o_redirect_valid), 32'h0);
    chk("rst_pc",    o_redirect_pc,         32'h0);
    chk("rst_taken", 32'(o_taken_cnt),      32'h0);
    chk("rst_stall", 32'(o_stall_cnt),      32'h0);
    i_rst = 1'b1;
    neg();
    chk("rel_outs", {29'h0, o_stall, o_flush_ifid, o_redirect_valid}, 32'h0);

    // 2: no-hazard taken BEQ to 0x40
    nxt(); br(1'b1, 32'h40, 5'd1, 5'd2);
    neg(); chk("t2_flush", 32'(o_flush_ifid), 32'h1); chk("t2_nostall", 32'(o_stall), 32'h0);
    nxt(); idle_in();
    neg(); chk("t2_valid", 32'(o_redirect_valid), 32'h1); chk("t2_pc", o_redirect_pc, 32'h40);
    nxt();
    neg(); chk("t2_idle", 32'(o_redirect_valid), 32'h0); chk("t2_taken", 32'(o_taken_cnt), 32'h1);

    // 3: lw $5 in EX feeding BEQ rs=$5
    nxt(); br(1'b1, 32'h100, 5'd5, 5'd6);
    i_ex_memread = 1'b1; i_ex_regwrite = 1'b1; i_ex_rd = 5'd5;
    neg(); chk("t3_stall0", 32'(o_stall), 32'h1); chk("t3_bub0", 32'(o_bubble_idex), 32'h1);
    nxt(); i_ex_memread = 1'b0; i_ex_regwrite = 1'b0; i_ex_rd = 5'd0;
    i_mem_memread = 1'b1; i_mem_rd = 5'd5;
    neg(); chk("t3_stall1", 32'(o_stall), 32'h1);
    nxt(); i_mem_memread = 1'b0; i_mem_rd = 5'd0;
    neg(); chk("t3_go", 32'(o_stall), 32'h0); chk("t3_flush", 32'(o_flush_ifid), 32'h1);
    nxt(); idle_in();
    neg(); chk("t3_pc", o_redirect_pc, 32'h100); chk("t3_scnt", 32'(o_stall_cnt), 32'h2);
    nxt();
    neg(); chk("t3_taken", 32'(o_taken_cnt), 32'h2);

    // 4: $0 never matches; ALU $3 costs exactly one stall cycle
    nxt(); br(1'b0, 32'h0, 5'd0, 5'd7); i_ex_regwrite = 1'b1; i_ex_rd = 5'd0;
    neg(); chk("t4_zero", 32'(o_stall), 32'h0);
    nxt(); i_ex_rd = 5'd3; i_id_rs = 5'd3;
    neg(); chk("t4_alu", 32'(o_stall), 32'h1);
    nxt(); i_ex_regwrite = 1'b0; i_ex_rd = 5'd0;
    neg(); chk("t4_clear", 32'(o_stall), 32'h0);
    nxt(); idle_in();
    neg(); chk("t4_scnt", 32'(o_stall_cnt), 32'h3);

    // 5: EX change beats ID taken; fetch holds off three cycles; then overwrite
    nxt(); br(1'b1, 32'h40, 5'd1, 5'd2);
    i_ex_change_pc = 1'b1; i_ex_target = 32'h80; i_if_ready = 1'b0;
    neg(); chk("t5_flush", 32'(o_flush_ifid), 32'h1); chk("t5_nostall", 32'(o_stall), 32'h0);
    nxt(); idle_in(); i_if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      neg(); chk("t5_hold_v", 32'(o_redirect_valid), 32'h1); chk("t5_hold_pc", o_redirect_pc, 32'h80);
      nxt();
    end
    i_ex_change_pc = 1'b1; i_ex_target = 32'h200;
    neg(); chk("t5_ovr_flush", 32'(o_flush_ifid), 32'h1);
    nxt(); i_ex_change_pc = 1'b0; i_ex_target = 32'h0; i_if_ready = 1'b1;
    neg(); chk("t5_ovr_pc", o_redirect_pc, 32'h200); chk("t5_ovr_v", 32'(o_redirect_valid), 32'h1);
    chk("t5_scnt", 32'(o_stall_cnt), 32'h6); chk("t5_taken", 32'(o_taken_cnt), 32'h4);
    nxt();
    neg(); chk("t5_done", 32'(o_redirect_valid), 32'h0);

    // 6a: reset during STALL
    nxt(); br(1'b1, 32'h44, 5'd4, 5'd0); i_ex_memread = 1'b1; i_ex_rd = 5'd4;
    nxt(); idle_in(); i_rst = 1'b0;
    neg(); chk("t6a_gate", 32'(o_stall), 32'h0);
    nxt(); i_rst = 1'b1;
    neg(); chk("t6a_v", 32'(o_redirect_valid), 32'h0); chk("t6a_scnt", 32'(o_stall_cnt), 32'h0);

    // 6b: reset during REDIR drops the pending redirect
    nxt(); br(1'b1, 32'h44, 5'd1, 5'd2);
    nxt(); idle_in(); i_if_ready = 1'b0; i_rst = 1'b0;
    nxt(); i_rst = 1'b1; i_if_ready = 1'b1;
    neg(); chk("t6b_v", 32'(o_redirect_valid), 32'h0); chk("t6b_pc", o_redirect_pc, 32'h0);

    // 6c: EX change aborts a load-use STALL
    nxt(); br(1'b1, 32'h48, 5'd8, 5'd0); i_ex_memread = 1'b1; i_ex_rd = 5'd8;
    nxt(); idle_in(); i_ex_change_pc = 1'b1; i_ex_target = 32'h300;
    neg(); chk("t6c_flush", 32'(o_flush_ifid), 32'h1);
    nxt(); idle_in();
    neg(); chk("t6c_pc", o_redirect_pc, 32'h300);
    nxt();

    // 6d: saturation of both counters
    br(1'b0, 32'h0, 5'd9, 5'd0); i_ex_regwrite = 1'b1; i_ex_rd = 5'd9;
    repeat (CMAX + 5) nxt();
    idle_in();
    neg(); chk("t6d_ssat", 32'(o_stall_cnt), 32'hFF);
    nxt(); i_if_ready = 1'b0; i_ex_change_pc = 1'b1;
    for (int i = 0; i < CMAX + 5; i++) begin
      i_ex_target = 32'h1000 + 32'(i * 4);
      nxt();
    end
    idle_in();
    neg(); chk("t6d_tsat", 32'(o_taken_cnt), 32'hFF);
    nxt(); nxt();
    neg(); chk("t6d_ssat2", 32'(o_stall_cnt), 32'hFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
